// File: rtl/skin_segm_ctrl_pkg.sv
// Shared types and constants for the skin segmentation controller.
// Config map, FSM encoding and reset thresholds.
package skin_segm_ctrl_pkg;

  localparam logic [2:0] ADDR_HMIN = 3'd0;
  localparam logic [2:0] ADDR_HMAX = 3'd1;
  localparam logic [2:0] ADDR_SMIN = 3'd2;
  localparam logic [2:0] ADDR_SMAX = 3'd3;
  localparam logic [2:0] ADDR_VMIN = 3'd4;
  localparam logic [2:0] ADDR_VMAX = 3'd5;
  localparam logic [2:0] ADDR_CTRL = 3'd6;

  localparam logic [7:0] THR_MIN_RST = 8'h00;
  localparam logic [7:0] THR_MAX_RST = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] hmin;
    logic [7:0] hmax;
    logic [7:0] smin;
    logic [7:0] smax;
    logic [7:0] vmin;
    logic [7:0] vmax;
  } thr_t;

  localparam thr_t THR_RST = '{
    hmin: THR_MIN_RST,
    hmax: THR_MAX_RST,
    smin: THR_MIN_RST,
    smax: THR_MAX_RST,
    vmin: THR_MIN_RST,
    vmax: THR_MAX_RST
  };

endpackage

// File: rtl/skin_segm_ctrl_range_cmp.sv
// Inclusive unsigned window compare for one 8-bit channel.
// An inverted window (lo > hi) never matches.
module hsv_range_cmp (
  input  logic [7:0] val,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic       hit
);

  assign hit = (lo <= hi)
             && (val >= lo)
             && (val <= hi);

endmodule

// File: rtl/skin_segm_ctrl.sv
// Skin pixel classifier and per-frame counter behind rgb2hsv.
// Thresholds are double-buffered and swap at frame start.
module skin_segm_ctrl
  import skin_segm_ctrl_pkg::*;
#(
  parameter logic VSYNC_ACT = 1'b1,
  parameter int   CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_de,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic [7:0]       H,
  input  logic [7:0]       S,
  input  logic [7:0]       V,
  input  logic             hsv_de,
  output logic             hsv_ce,
  output logic             skin,
  output logic             skin_de,
  output logic             frame_done,
  output logic [CNT_W-1:0] skin_count,
  output logic             busy
);

  thr_t             sh_thr;
  thr_t             act_thr;
  logic             sh_en;
  logic             vsync_q;
  logic             frame_start;
  logic             h_hit;
  logic             s_hit;
  logic             v_hit;
  logic             hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_first;
  state_t           state;

  // hsync/de ride along with the HSV stream; only vsync matters here
  logic unused_timing;
  assign unused_timing = ^{in_hsync, in_de};

  assign frame_start = (vsync_q != VSYNC_ACT)
                    && (in_vsync == VSYNC_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= ~VSYNC_ACT;
    end else begin
      vsync_q <= in_vsync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_thr <= THR_RST;
      sh_en  <= 1'b0;
    end else if (cfg_wr) begin
      unique case (1'b1)
        (cfg_addr == ADDR_HMIN): sh_thr.hmin <= cfg_wdata;
        (cfg_addr == ADDR_HMAX): sh_thr.hmax <= cfg_wdata;
        (cfg_addr == ADDR_SMIN): sh_thr.smin <= cfg_wdata;
        (cfg_addr == ADDR_SMAX): sh_thr.smax <= cfg_wdata;
        (cfg_addr == ADDR_VMIN): sh_thr.vmin <= cfg_wdata;
        (cfg_addr == ADDR_VMAX): sh_thr.vmax <= cfg_wdata;
        (cfg_addr == ADDR_CTRL): sh_en       <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // actives take the pre-write shadow value on a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_thr <= THR_RST;
    end else if (frame_start) begin
      act_thr <= sh_thr;
    end
  end

  hsv_range_cmp u_cmp_h (
    .val (H),
    .lo  (act_thr.hmin),
    .hi  (act_thr.hmax),
    .hit (h_hit)
  );

  hsv_range_cmp u_cmp_s (
    .val (S),
    .lo  (act_thr.smin),
    .hi  (act_thr.smax),
    .hit (s_hit)
  );

  hsv_range_cmp u_cmp_v (
    .val (V),
    .lo  (act_thr.vmin),
    .hi  (act_thr.vmax),
    .hit (v_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skin    <= 1'b0;
      skin_de <= 1'b0;
    end else begin
      skin_de <= hsv_de;
      skin    <= hsv_de & h_hit & s_hit & v_hit;
    end
  end

  assign hit       = skin_de & skin;
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign cnt_first = CNT_W'(hit);

  // a hit in the frame-start cycle seeds the new frame's count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hsv_ce     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      skin_count <= '0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (sh_en) begin
            state  <= ST_WAIT;
            hsv_ce <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!sh_en) begin
            state  <= ST_IDLE;
            hsv_ce <= 1'b0;
          end else if (frame_start) begin
            state <= ST_ACTIVE;
            busy  <= 1'b1;
            cnt   <= cnt_first;
          end
        end
        ST_ACTIVE: begin
          if (frame_start) begin
            frame_done <= 1'b1;
            skin_count <= cnt;
            if (sh_en) begin
              cnt <= cnt_first;
            end else begin
              state  <= ST_IDLE;
              busy   <= 1'b0;
              hsv_ce <= 1'b0;
              cnt    <= '0;
            end
          end else if (hit) begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          hsv_ce <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skin_segm_ctrl.sv
// Scoreboard bench for skin_segm_ctrl with a frame-level model.
// Two instances share stimulus: default counter and 4-bit counter.
module tb_skin_segm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vsync, in_hsync, in_de;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  h, s, v;
  logic        hsv_de;
  logic        hsv_ce, skin, skin_de, frame_done, busy;
  logic [19:0] skin_count;
  logic        hsv_ce4, skin4, skin_de4, frame_done4, busy4;
  logic [3:0]  skin_count4;

  always #5 clk = ~clk;

  skin_segm_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .H(h), .S(s), .V(v), .hsv_de(hsv_de),
    .hsv_ce(hsv_ce), .skin(skin), .skin_de(skin_de),
    .frame_done(frame_done), .skin_count(skin_count), .busy(busy)
  );

  skin_segm_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .H(h), .S(s), .V(v), .hsv_de(hsv_de),
    .hsv_ce(hsv_ce4), .skin(skin4), .skin_de(skin_de4),
    .frame_done(frame_done4), .skin_count(skin_count4), .busy(busy4)
  );

  typedef struct {
    logic [19:0] c20;
    logic [3:0]  c4;
  } fexp_t;

  int    checks = 0;
  int    errors = 0;
  bit    sq[$];
  fexp_t fq[$];

  // reference model: shadow/active tables, mode 0=idle 1=wait 2=active
  int sh[7];
  int act[6];
  int mode;
  int cnt20, cnt4;
  bit pend;
  bit vprev;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic bit mmatch(int hh, int ss, int vv);
    return act[0] <= hh && hh <= act[1]
        && act[2] <= ss && ss <= act[3]
        && act[4] <= vv && vv <= act[5];
  endfunction

  task automatic model_reset();
    sh  = '{0, 255, 0, 255, 0, 255, 0};
    for (int i = 0; i < 6; i++) act[i] = sh[i];
    mode  = 0;
    cnt20 = 0;
    cnt4  = 0;
    pend  = 1'b0;
    vprev = 1'b0;
  endtask

  task automatic step();
    bit    hit, fs, np, en;
    fexp_t e;
    hit = pend;
    fs  = in_vsync && !vprev;
    en  = (sh[6] & 1) != 0;
    np  = hsv_de && mmatch(int'(h), int'(s), int'(v));
    if (hsv_de) sq.push_back(np);
    case (mode)
      0: begin
        cnt20 = 0;
        cnt4  = 0;
        if (en) mode = 1;
      end
      1: begin
        if (!en) mode = 0;
        else if (fs) begin
          mode  = 2;
          cnt20 = int'(hit);
          cnt4  = int'(hit);
        end
      end
      default: begin
        if (fs) begin
          e.c20 = cnt20[19:0];
          e.c4  = cnt4[3:0];
          fq.push_back(e);
          if (en) begin
            cnt20 = int'(hit);
            cnt4  = int'(hit);
          end else begin
            mode  = 0;
            cnt20 = 0;
            cnt4  = 0;
          end
        end else if (hit) begin
          if (cnt20 < 20'hFFFFF) cnt20++;
          if (cnt4 < 15) cnt4++;
        end
      end
    endcase
    if (fs) for (int i = 0; i < 6; i++) act[i] = sh[i];
    pend = np;
    if (cfg_wr && cfg_addr < 3'd7) sh[cfg_addr] = int'(cfg_wdata);
    vprev = in_vsync;
    @(posedge clk);
    #1;
    chk("hsv_ce", {31'd0, hsv_ce}, {31'd0, mode != 0});
    chk("busy", {31'd0, busy}, {31'd0, mode == 2});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (skin_de) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL skin_extra: got skin_de=1 expected none");
        end else begin
          chk("skin", {31'd0, skin}, {31'd0, sq.pop_front()});
        end
      end else begin
        chk("skin_no_de", {31'd0, skin}, 32'd0);
      end
      if (frame_done) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_extra: got pulse expected none");
        end else begin
          fexp_t e;
          e = fq.pop_front();
          chk("skin_count", {12'd0, skin_count}, {12'd0, e.c20});
          chk("skin_count4", {28'd0, skin_count4}, {28'd0, e.c4});
        end
      end
    end
  end

  task automatic cfg(input int a, input int d);
    hsv_de    = 1'b0;
    cfg_wr    = 1'b1;
    cfg_addr  = a[2:0];
    cfg_wdata = d[7:0];
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic pix(input int hh, input int ss, input int vv);
    h      = hh[7:0];
    s      = ss[7:0];
    v      = vv[7:0];
    hsv_de = 1'b1;
    step();
    hsv_de = 1'b0;
  endtask

  function automatic int near(int b);
    int r;
    r = b + int'($urandom_range(0, 4)) - 2;
    if ($urandom_range(0, 2) == 0) r = int'($urandom_range(0, 255));
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic rand_pix();
    int hh, ss, vv;
    hh     = near(sh[$urandom_range(0, 1)]);
    ss     = near(sh[2 + $urandom_range(0, 1)]);
    vv     = near(sh[4 + $urandom_range(0, 1)]);
    h      = hh[7:0];
    s      = ss[7:0];
    v      = vv[7:0];
    hsv_de = ($urandom_range(0, 3) != 0);
  endtask

  task automatic vs_pulse(input bit rnd);
    in_vsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rnd) rand_pix();
      else hsv_de = 1'b0;
      step();
    end
    in_vsync = 1'b0;
    hsv_de   = 1'b0;
    step();
  endtask

  initial begin
    int m, n;
    rst_n     = 1'b0;
    in_vsync  = 1'b0;
    in_hsync  = 1'b0;
    in_de     = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_wdata = 8'd0;
    h         = 8'd0;
    s         = 8'd0;
    v         = 8'd0;
    hsv_de    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsv_ce", {31'd0, hsv_ce}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_skin", {31'd0, skin}, 32'd0);
    chk("rst_skin_de", {31'd0, skin_de}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_skin_count", {12'd0, skin_count}, 32'd0);
    rst_n = 1'b1;
    step();

    cfg(0, 10);
    cfg(1, 40);
    cfg(2, 50);
    cfg(3, 200);
    cfg(4, 60);
    cfg(5, 255);
    cfg(6, 1);
    step();
    vs_pulse(1'b0);

    pix(8'h1A, 8'h80, 8'h7C);
    pix(8'h50, 8'h80, 8'h7C);
    step();
    vs_pulse(1'b0);

    m = 100;
    n = 50;
    while (m + n > 0) begin
      if (int'($urandom_range(0, m + n - 1)) < m) begin
        pix($urandom_range(10, 40), $urandom_range(50, 200),
            $urandom_range(60, 255));
        m--;
      end else begin
        pix($urandom_range(41, 255), $urandom_range(50, 200),
            $urandom_range(60, 255));
        n--;
      end
    end
    step();
    vs_pulse(1'b0);

    pix(8'h30, 8'h80, 8'h7C);
    cfg(1, 8'h20);
    pix(8'h30, 8'h80, 8'h7C);
    step();
    vs_pulse(1'b0);
    pix(8'h30, 8'h80, 8'h7C);
    pix(8'h1A, 8'h80, 8'h7C);
    step();

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 60; i++) begin
        rand_pix();
        if ($urandom_range(0, 9) == 0) begin
          cfg_wr    = 1'b1;
          cfg_addr  = 3'($urandom_range(0, 7));
          cfg_wdata = 8'($urandom_range(0, 255));
          if (cfg_addr == 3'd6) cfg_wdata[0] = ($urandom_range(0, 3) != 0);
        end
        step();
        cfg_wr = 1'b0;
      end
      vs_pulse(1'b1);
    end
    hsv_de = 1'b0;
    step();

    cfg(6, 1);
    step();
    vs_pulse(1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_pix();
      step();
    end
    cfg(6, 0);
    for (int i = 0; i < 20; i++) begin
      rand_pix();
      step();
    end
    hsv_de = 1'b0;
    step();
    vs_pulse(1'b0);
    repeat (3) step();

    cfg(6, 1);
    step();
    vs_pulse(1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_pix();
      step();
    end
    hsv_de = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hsv_ce", {31'd0, hsv_ce}, 32'd0);
    in_vsync = 1'b1;
    rst_n    = 1'b1;
    step();
    step();
    in_vsync = 1'b0;
    pix(8'h05, 8'h05, 8'h05);
    repeat (4) step();

    checks++;
    if (sq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d skin %0d frames pending expected 0",
               sq.size(), fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/skin_segm_ctrl.md
SKIN_SEGM_CTRL -- requirements
Module: skin_segm_ctrl

Interface
REQ-001 Parameter VSYNC_ACT, default 1'b1: vsync level that marks the sync pulse; frame start is the inactive-to-active transition.
REQ-002 Parameter CNT_W, default 20: width of the per-frame skin pixel counter.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_vsync, in_hsync, in_de  in  1 each  camera timing, same timing as the RGB fed to rgb2hsv.
REQ-006 cfg_wr  in  1  configuration write strobe, one write per cycle.
REQ-007 cfg_addr  in  3  0=Hmin 1=Hmax 2=Smin 3=Smax 4=Vmin 5=Vmax 6=ctrl (bit0 enable).
REQ-008 cfg_wdata  in  8  write data.
REQ-009 H, S, V, hsv_de  in  8,8,8,1  rgb2hsv outputs and their out_de.
REQ-010 hsv_ce  out  1  clock enable driven to rgb2hsv ce.
REQ-011 skin, skin_de  out  1,1  per-pixel classification and its valid.
REQ-012 frame_done  out  1  one-cycle pulse at frame start after a counted frame.
REQ-013 skin_count  out  CNT_W  skin pixels in the last completed frame.
REQ-014 busy  out  1  high in ACTIVE state.

Function
REQ-015 Writes SHALL go to shadow registers; shadows SHALL copy to active registers only at frame start, so thresholds never change mid-frame.
REQ-016 FSM states: IDLE, WAIT_FRAME, ACTIVE.
REQ-017 IDLE -> WAIT_FRAME when shadow enable=1; WAIT_FRAME -> ACTIVE at frame start; WAIT_FRAME -> IDLE if shadow enable cleared.
REQ-018 In ACTIVE, at each frame start: pulse frame_done, latch skin_count, clear the running counter, load actives; stay ACTIVE if shadow enable=1, else go IDLE.
REQ-019 Frame start SHALL be detected from a registered copy of in_vsync: prev inactive and current active.
REQ-020 hsv_ce SHALL be 1 in WAIT_FRAME and ACTIVE, 0 in IDLE.
REQ-021 skin SHALL be registered with 1-cycle latency from hsv_de: skin_de=hsv_de delayed 1, skin=hsv_de AND Hmin<=H<=Hmax AND Smin<=S<=Smax AND Vmin<=V<=Vmax (unsigned, inclusive).
REQ-022 If min>max on any channel, that channel SHALL never match (skin=0).
REQ-023 Running counter SHALL increment on each cycle skin_de&skin in ACTIVE and SHALL saturate at 2^CNT_W-1.
REQ-024 A skin pixel coinciding with the frame-start cycle SHALL be counted into the new frame, not the latched one.
REQ-025 A cfg write in the frame-start cycle SHALL land in shadow only; actives get the prior shadow value.
REQ-026 Outside ACTIVE, skin and skin_de SHALL still be produced from actives; counter holds at 0.

Reset
REQ-027 On rst_n low: state=IDLE, all shadow/active thresholds = 0 except Hmax/Smax/Vmax = 8'hFF, enable=0.
REQ-028 On rst_n low: hsv_ce, skin, skin_de, frame_done, busy = 0; skin_count and running counter = 0; vsync history = inactive.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no frame_done on release.

Structure
REQ-030 Shared package: cfg address constants, FSM state encoding, reset threshold values.
REQ-031 One sub-module, hsv_range_cmp: combinational min/max window compare for one 8-bit channel, instantiated three times.

Verification
REQ-032 Reset, enable=1, thresholds H[10,40] S[50,200] V[60,255], then vsync edge -> busy=1 next cycle, hsv_ce=1.
REQ-033 Feed H=0x1A S=0x80 V=0x7C with hsv_de=1 -> skin=1 one cycle later; H=0x50 -> skin=0.
REQ-034 Frame of 100 matching + 50 non-matching pixels, next vsync edge -> frame_done single pulse, skin_count=100.
REQ-035 Write Hmax=0x20 mid-frame -> classification of H=0x30 unchanged until next frame start, then skin=0.
REQ-036 CNT_W=4, 20 matching pixels in one frame -> skin_count=15.
REQ-037 Clear enable mid-frame -> frame completes, frame_done at next frame start, then IDLE with hsv_ce=0.
